sd_arbiter: RTL and testbench
=============================

Name: sd_arbiter

Overview:
- Shares the single SD block-level port of the ARM SPI I/O block (sd_lba/sd_rd/sd_wr/sd_ack plus the 512-byte sector buffer bus) between two requesters, e.g. a floppy controller and a hard-disk controller.
- Arbitrates round-robin, latches the winning request, and sequences the rd/wr -> ack-rise -> ack-fall handshake.
- Routes sector-buffer traffic only to the granted requester.
- Sits in clk_sys, between the I/O block and the disk controllers.

Parameters:
- TIMEOUT, 24'd10000000, clk_sys cycles to wait for ack rise before abandoning a request (0 = never time out).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sd_lba  out  32  LBA to I/O block.
- sd_rd  out  1  read request to I/O block.
- sd_wr  out  1  write request to I/O block.
- sd_ack  in  1  ack from I/O block; SPI-clock domain, asynchronous to clk_sys.
- sd_buff_addr  in  9  sector buffer address from I/O block.
- sd_buff_dout  in  8  sector byte from I/O block.
- sd_buff_wr  in  1  buffer write strobe from I/O block.
- sd_buff_din  out  8  byte to I/O block, muxed from the granted client.
- cN_lba  in  32  client N LBA (N = 0, 1).
- cN_rd  in  1  client N read request, level, held until cN_done.
- cN_wr  in  1  client N write request, level, held until cN_done.
- cN_busy  out  1  client N request is granted and in progress.
- cN_done  out  1  one-cycle pulse: client N transfer finished.
- cN_err  out  1  one-cycle pulse, coincident with cN_done: client N request timed out.
- cN_buff_addr  out  9  client N buffer address.
- cN_buff_dout  out  8  client N buffer byte.
- cN_buff_wr  out  1  client N buffer write strobe.
- cN_buff_din  in  8  client N buffer byte for writes.

Behaviour:
- Reset (async, reset=1): state IDLE; sd_rd=sd_wr=0; sd_lba=0; all busy/done/err=0; last_grant=1, so client 0 has priority first.
- sd_ack passes through a 2-flop synchronizer (ack_s). All edge decisions use ack_s and its 1-cycle delayed copy.
- State IDLE:
  - A client is pending if cN_rd|cN_wr.
  - If both are pending, grant the client != last_grant. Otherwise grant the single pending client.
  - On grant: latch lba, latch op (wr has priority if rd and wr are both high), set cN_busy=1, last_grant<=N, clear timer. Next state REQ.
  - Grant is registered: sd_rd/sd_wr rise 1 cycle after the cycle the request is sampled.
- State REQ:
  - Drive sd_lba = latched lba and sd_rd/sd_wr = latched op; hold until ack_s rises.
  - On ack_s rising: deassert sd_rd/sd_wr in the same edge, go to XFER.
  - If TIMEOUT != 0 and the timer reaches TIMEOUT-1 with no ack: deassert sd_rd/sd_wr, pulse cN_done and cN_err, clear busy, go to IDLE.
- State XFER:
  - Wait for ack_s falling. Then pulse cN_done, clear cN_busy, go to IDLE.
  - A new grant can occur no earlier than the cycle after done.
- Buffer routing is combinational, using the registered grant and state:
  - cN_buff_addr and cN_buff_dout are broadcast to both clients.
  - cN_buff_wr = sd_buff_wr & granted(N) & (state != IDLE); the other client's strobe is forced 0.
  - sd_buff_din = cgrant_buff_din while not IDLE, 0 in IDLE.
  - A stray sd_buff_wr in IDLE reaches no client.
- Client deasserting rd/wr mid-transfer is ignored. The transfer completes and done still pulses, because the ARM cannot abort.
- Client reasserting immediately after done: treated as a new request. If the other client is pending it wins, so the two alternate.
- The timer is 24 bits and saturates; it runs only in REQ.
- Reset mid-transfer drops sd_rd/sd_wr immediately. No done pulse is generated.

Test Plan:
- Single read: c0_rd=1, c0_lba=32'h1234; ack high at +10 cycles, low at +600 -> sd_rd=1, sd_lba=32'h1234 from cycle 1, sd_rd=0 after the ack rise, c0_done pulse 1 cycle after synced ack fall, c1 sees no buff_wr.
- Write data path: c1_wr=1, c1_buff_din=8'hA5; during XFER -> sd_buff_din=8'hA5, sd_wr dropped after ack; c1_done pulses, c1_err=0.
- Simultaneous requests from reset: c0_rd and c1_rd held high -> c0 is served first, then c1, then c0 again. Alternation is strict, with no back-to-back repeat of the same client.
- Rd+wr both high on c0 -> sd_wr=1, sd_rd=0.
- Timeout with TIMEOUT=100 and ack never asserted -> sd_rd high for 100 cycles, then c0_done and c0_err pulse together, state back to IDLE, c1 granted next if pending.
- Async reset mid-XFER -> sd_rd, sd_wr, busy all 0 immediately; no done pulse; next request after reset is granted to client 0.

Source files
------------

// File: rtl/sd_arbiter.sv
// sd_arbiter
//
// Shares the single SD block-level port of the ARM SPI I/O block between
// two disk controllers (e.g. floppy and hard disk).  Requests are arbitrated
// round-robin, the winning LBA and operation are latched, and the
// rd/wr -> ack-rise -> ack-fall handshake is sequenced.  Sector-buffer traffic
// is routed only to the client currently being served.
//
// Ports:
//   clk_sys, reset              system clock, async active-high reset
//   sd_lba/sd_rd/sd_wr          request to the I/O block
//   sd_ack                      ack from the I/O block (SPI clock domain)
//   sd_buff_addr/dout/wr        sector buffer bus from the I/O block
//   sd_buff_din                 sector byte to the I/O block (granted client)
//   cN_lba/cN_rd/cN_wr          client N request (level, held until cN_done)
//   cN_busy/cN_done/cN_err      client N status (done/err are 1-cycle pulses)
//   cN_buff_addr/dout/wr        client N view of the sector buffer bus
//   cN_buff_din                 client N write data
module sd_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd10000000
) (
    input  logic        clk_sys,
    input  logic        reset,

    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,

    input  logic [31:0] c0_lba,
    input  logic        c0_rd,
    input  logic        c0_wr,
    output logic        c0_busy,
    output logic        c0_done,
    output logic        c0_err,
    output logic [8:0]  c0_buff_addr,
    output logic [7:0]  c0_buff_dout,
    output logic        c0_buff_wr,
    input  logic [7:0]  c0_buff_din,

    input  logic [31:0] c1_lba,
    input  logic        c1_rd,
    input  logic        c1_wr,
    output logic        c1_busy,
    output logic        c1_done,
    output logic        c1_err,
    output logic [8:0]  c1_buff_addr,
    output logic [7:0]  c1_buff_dout,
    output logic        c1_buff_wr,
    input  logic [7:0]  c1_buff_din
);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic [23:0] timer;

    logic        ack_meta;
    logic        ack_s;
    logic        ack_d;

    logic        pend0;
    logic        pend1;
    logic        pick;
    logic        sel_rd;
    logic        sel_wr;
    logic [31:0] sel_lba;
    logic        ack_rise;
    logic        ack_fall;
    logic        active;

    // sd_ack comes from the SPI clock domain; two flops before any use,
    // plus one more to find its edges.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
            ack_d    <= 1'b0;
        end else begin
            ack_meta <= sd_ack;
            ack_s    <= ack_meta;
            ack_d    <= ack_s;
        end
    end

    assign ack_rise = ack_s & ~ack_d;
    assign ack_fall = ~ack_s & ack_d;

    // Round-robin pick: with both pending the client not served last wins.
    assign pend0   = c0_rd | c0_wr;
    assign pend1   = c1_rd | c1_wr;
    assign pick    = (pend0 & pend1) ? ~last_grant : pend1;
    assign sel_rd  = pick ? c1_rd  : c0_rd;
    assign sel_wr  = pick ? c1_wr  : c0_wr;
    assign sel_lba = pick ? c1_lba : c0_lba;

    // Arbitration and handshake sequencing.  No grant is made while a
    // done pulse is out, so a client that drops its request in response to
    // done is never re-granted on its stale level.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            timer      <= 24'd0;
            sd_lba     <= 32'd0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            c0_busy    <= 1'b0;
            c1_busy    <= 1'b0;
            c0_done    <= 1'b0;
            c1_done    <= 1'b0;
            c0_err     <= 1'b0;
            c1_err     <= 1'b0;
        end else begin
            c0_done <= 1'b0;
            c1_done <= 1'b0;
            c0_err  <= 1'b0;
            c1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if ((pend0 | pend1) && !(c0_done | c1_done)) begin
                        grant      <= pick;
                        last_grant <= pick;
                        sd_lba     <= sel_lba;
                        sd_wr      <= sel_wr;
                        sd_rd      <= sel_rd & ~sel_wr;
                        timer      <= 24'd0;
                        if (pick) c1_busy <= 1'b1;
                        else      c0_busy <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end else if (TIMEOUT != 24'd0 && timer == TIMEOUT - 24'd1) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        if (grant) begin
                            c1_done <= 1'b1;
                            c1_err  <= 1'b1;
                            c1_busy <= 1'b0;
                        end else begin
                            c0_done <= 1'b1;
                            c0_err  <= 1'b1;
                            c0_busy <= 1'b0;
                        end
                        state <= IDLE;
                    end else if (timer != 24'hFFFFFF) begin
                        timer <= timer + 24'd1;
                    end
                end
                XFER: begin
                    if (ack_fall) begin
                        if (grant) begin
                            c1_done <= 1'b1;
                            c1_busy <= 1'b0;
                        end else begin
                            c0_done <= 1'b1;
                            c0_busy <= 1'b0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer routing: address/data broadcast, strobe and write data only
    // for the granted client, and nothing at all while idle.
    assign active       = (state != IDLE);
    assign c0_buff_addr = sd_buff_addr;
    assign c1_buff_addr = sd_buff_addr;
    assign c0_buff_dout = sd_buff_dout;
    assign c1_buff_dout = sd_buff_dout;
    assign c0_buff_wr   = sd_buff_wr & active & ~grant;
    assign c1_buff_wr   = sd_buff_wr & active & grant;
    assign sd_buff_din  = active ? (grant ? c1_buff_din : c0_buff_din) : 8'd0;

endmodule

// File: tb/tb_sd_arbiter.sv
// tb_sd_arbiter
//
// Directed bench for sd_arbiter (TIMEOUT = 100): single read, write data
// path, strict alternation of two held requests, rd+wr priority, request
// timeout, and async reset in the middle of a transfer.
module tb_sd_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack       = 1'b0;
    logic [8:0]  sd_buff_addr = 9'd0;
    logic [7:0]  sd_buff_dout = 8'd0;
    logic        sd_buff_wr   = 1'b0;
    logic [7:0]  sd_buff_din;
    logic [31:0] c0_lba = 32'd0, c1_lba = 32'd0;
    logic        c0_rd = 1'b0, c0_wr = 1'b0, c1_rd = 1'b0, c1_wr = 1'b0;
    logic        c0_busy, c0_done, c0_err, c1_busy, c1_done, c1_err;
    logic [8:0]  c0_buff_addr, c1_buff_addr;
    logic [7:0]  c0_buff_dout, c1_buff_dout;
    logic        c0_buff_wr, c1_buff_wr;
    logic [7:0]  c0_buff_din = 8'h5A, c1_buff_din = 8'hA5;

    int n_compared   = 0;
    int n_mismatched = 0;

    sd_arbiter #(.TIMEOUT(24'd100)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .c0_lba(c0_lba), .c0_rd(c0_rd), .c0_wr(c0_wr),
        .c0_busy(c0_busy), .c0_done(c0_done), .c0_err(c0_err),
        .c0_buff_addr(c0_buff_addr), .c0_buff_dout(c0_buff_dout),
        .c0_buff_wr(c0_buff_wr), .c0_buff_din(c0_buff_din),
        .c1_lba(c1_lba), .c1_rd(c1_rd), .c1_wr(c1_wr),
        .c1_busy(c1_busy), .c1_done(c1_done), .c1_err(c1_err),
        .c1_buff_addr(c1_buff_addr), .c1_buff_dout(c1_buff_dout),
        .c1_buff_wr(c1_buff_wr), .c1_buff_din(c1_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic r1, input logic w1);
        c0_rd = r0;
        c0_wr = w0;
        c1_rd = r1;
        c1_wr = w1;
    endtask

    // Waits (bounded) for a grant, then checks which client got it.
    task automatic waitGrant(input string tag, input logic [1:0] exp);
        for (int i = 0; i < 10; i++) begin
            if (c0_busy | c1_busy) break;
            tick();
        end
        checkOutput(tag, {30'd0, c1_busy, c0_busy}, {30'd0, exp});
    endtask

    // Called one cycle after the grant edge: checks the request, drives the
    // ack handshake, exercises the buffer bus, and checks the done pulse.
    task automatic runHandshake(input logic cl, input logic exp_wr,
                                input logic [31:0] exp_lba, input int hold);
        logic [7:0] exp_din;
        exp_din = cl ? 8'hA5 : 8'h5A;
        checkOutput("req_rd", sd_rd, !exp_wr);
        checkOutput("req_wr", sd_wr, exp_wr);
        checkOutput("req_lba", sd_lba, exp_lba);
        checkOutput("busy_own", cl ? c1_busy : c0_busy, 1);
        checkOutput("busy_other", cl ? c0_busy : c1_busy, 0);
        repeat (9) tick();
        checkOutput("req_hold", sd_rd | sd_wr, 1);
        sd_ack = 1'b1;
        repeat (2) tick();
        checkOutput("ack_sync_delay", sd_rd | sd_wr, 1);
        tick();
        checkOutput("ack_drop", sd_rd | sd_wr, 0);
        sd_buff_addr = 9'h155;
        sd_buff_dout = 8'hC3;
        sd_buff_wr   = 1'b1;
        #1;
        checkOutput("bwr_own", cl ? c1_buff_wr : c0_buff_wr, 1);
        checkOutput("bwr_other", cl ? c0_buff_wr : c1_buff_wr, 0);
        checkOutput("buff_din", sd_buff_din, exp_din);
        checkOutput("buff_addr", cl ? c1_buff_addr : c0_buff_addr, 9'h155);
        checkOutput("buff_dout", cl ? c1_buff_dout : c0_buff_dout, 8'hC3);
        sd_buff_wr = 1'b0;
        repeat (hold) tick();
        sd_ack = 1'b0;
        repeat (2) tick();
        checkOutput("done_early", cl ? c1_done : c0_done, 0);
        tick();
        checkOutput("done", cl ? c1_done : c0_done, 1);
        checkOutput("err", cl ? c1_err : c0_err, 0);
        checkOutput("busy_clr", cl ? c1_busy : c0_busy, 0);
        checkOutput("other_done", cl ? c0_done : c1_done, 0);
        tick();
        checkOutput("done_pulse", cl ? c1_done : c0_done, 0);
    endtask

    initial begin
        logic done_seen;
        $display("[TB] sd_arbiter bench start");
        repeat (3) tick();
        checkOutput("rst_rd", sd_rd, 0);
        checkOutput("rst_wr", sd_wr, 0);
        checkOutput("rst_lba", sd_lba, 0);
        checkOutput("rst_status", {c0_busy, c0_done, c0_err, c1_busy, c1_done, c1_err}, 0);
        reset = 1'b0;
        tick();

        // Single read on client 0, registered grant latency of one cycle.
        c0_lba = 32'h1234;
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("t1_grant_latency", {c1_busy, c0_busy, sd_rd}, 3'b011);
        runHandshake(1'b0, 1'b0, 32'h1234, 600);
        applyStimulus(0, 0, 0, 0);

        // Write on client 1.
        c1_lba = 32'hBEEF0001;
        applyStimulus(0, 0, 0, 1);
        waitGrant("t2_grant", 2'b10);
        runHandshake(1'b1, 1'b1, 32'hBEEF0001, 20);
        applyStimulus(0, 0, 0, 0);
        tick();

        // Stray buffer strobe while idle reaches nobody.
        sd_buff_wr = 1'b1;
        #1;
        checkOutput("idle_bwr", {c1_buff_wr, c0_buff_wr}, 0);
        checkOutput("idle_din", sd_buff_din, 0);
        sd_buff_wr = 1'b0;

        // Both held from reset: c0, c1, c0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1, 0, 1, 0);
        waitGrant("t3_first", 2'b01);
        runHandshake(1'b0, 1'b0, 32'h1234, 5);
        waitGrant("t3_second", 2'b10);
        runHandshake(1'b1, 1'b0, 32'hBEEF0001, 5);
        waitGrant("t3_third", 2'b01);
        runHandshake(1'b0, 1'b0, 32'h1234, 5);
        applyStimulus(0, 0, 0, 0);
        repeat (2) tick();

        // rd and wr both high: write wins.
        c0_lba = 32'h0000_0777;
        applyStimulus(1, 1, 0, 0);
        waitGrant("t4_grant", 2'b01);
        runHandshake(1'b0, 1'b1, 32'h0000_0777, 5);
        applyStimulus(0, 0, 0, 0);
        repeat (2) tick();

        // Timeout: no ack, request held exactly 100 cycles.
        applyStimulus(1, 0, 0, 0);
        waitGrant("t5_grant", 2'b01);
        repeat (99) tick();
        checkOutput("t5_still_req", sd_rd, 1);
        applyStimulus(1, 0, 1, 0);
        tick();
        checkOutput("t5_rd_drop", sd_rd, 0);
        checkOutput("t5_done_err", {c0_done, c0_err, c0_busy}, 3'b110);
        tick();
        checkOutput("t5_pulse_end", {c0_done, c0_err}, 0);
        applyStimulus(0, 0, 1, 0);
        waitGrant("t5_next_c1", 2'b10);
        runHandshake(1'b1, 1'b0, 32'hBEEF0001, 5);
        applyStimulus(0, 0, 0, 0);
        repeat (2) tick();

        // Async reset mid-transfer.
        applyStimulus(0, 0, 1, 0);
        waitGrant("t6_grant", 2'b10);
        repeat (3) tick();
        sd_ack = 1'b1;
        repeat (3) tick();
        checkOutput("t6_in_xfer", {c1_busy, sd_rd}, 2'b10);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_async_clear", {c0_busy, c1_busy, sd_rd, sd_wr}, 0);
        sd_ack = 1'b0;
        applyStimulus(0, 0, 0, 0);
        tick();
        reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            done_seen = done_seen | c0_done | c1_done;
        end
        checkOutput("t6_no_done", done_seen, 0);
        applyStimulus(1, 0, 1, 0);
        waitGrant("t6_after_reset", 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
